// File: rtl/i2c_slave_responder_if.sv
// I2C target bus pins plus local host/event port, grouped for the responder.
`timescale 1ns/1ps
interface i2c_slave_responder_if #(
  parameter int DW = 8,
  parameter int PW = 4
);
  logic          scl_i;
  logic          sda_i;
  logic          sda_oe;
  logic          busy;
  logic          rx_valid;
  logic [PW-1:0] rx_ptr;
  logic [DW-1:0] rx_data;
  logic          host_we;
  logic [PW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic [DW-1:0] host_rdata;

  modport slave (
    input  scl_i, sda_i, host_we, host_addr, host_wdata,
    output sda_oe, busy, rx_valid, rx_ptr, rx_data, host_rdata
  );

  modport master (
    output scl_i, sda_i, host_we, host_addr, host_wdata,
    input  sda_oe, busy, rx_valid, rx_ptr, rx_data, host_rdata
  );
endinterface

// File: rtl/i2c_slave_responder.sv
// I2C target with a small auto-incrementing register file and a local host port.
// Bus events reach the FSM 3 clk after they occur on the pins (2-FF sync + history FF).
`timescale 1ns/1ps
module i2c_slave_responder #(
  parameter int                        I2C_ADDR_WIDTH = 7,
  parameter int                        I2C_DATA_WIDTH = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR     = 7'h22,
  parameter int                        PTR_WIDTH      = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  i2c_slave_responder_if.slave  bus
);
  localparam int DW = I2C_DATA_WIDTH;
  localparam int AW = I2C_ADDR_WIDTH;
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK} state_t;

  logic [DW-1:0]        mem_q [2**PTR_WIDTH];
  logic                 scl_s1_q, scl_s2_q, scl_h_q;
  logic                 sda_s1_q, sda_s2_q, sda_h_q;
  state_t               state_q;
  logic [CW-1:0]        bit_cnt_q;
  logic [DW-2:0]        shift_q;
  logic [DW-2:0]        tx_q;
  logic [PTR_WIDTH-1:0] ptr_q;
  logic                 first_q, rw_q, ack_ph_q;
  logic                 sda_oe_q, busy_q, rx_valid_q;
  logic [PTR_WIDTH-1:0] rx_ptr_q;
  logic [DW-1:0]        rx_data_q;

  logic          scl_rise, scl_fall, start_c, stop_c, last_bit, bus_we;
  logic [DW-1:0] shift_d, rd_word;

  assign scl_rise = scl_s2_q & ~scl_h_q;
  assign scl_fall = ~scl_s2_q & scl_h_q;
  assign start_c  = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
  assign stop_c   = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
  assign shift_d  = {shift_q, sda_s2_q};
  assign last_bit = (bit_cnt_q == LAST);
  assign rd_word  = mem_q[ptr_q];
  assign bus_we   = (state_q == WR_BYTE) && scl_rise && last_bit && !first_q;

  assign bus.sda_oe     = sda_oe_q;
  assign bus.busy       = busy_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.rx_ptr     = rx_ptr_q;
  assign bus.rx_data    = rx_data_q;
  assign bus.host_rdata = mem_q[bus.host_addr];

  // Synchronizers reset high so an idle bus never looks like an edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {scl_s1_q, scl_s2_q, scl_h_q} <= 3'b111;
      {sda_s1_q, sda_s2_q, sda_h_q} <= 3'b111;
    end else begin
      {scl_s1_q, scl_s2_q, scl_h_q} <= {bus.scl_i, scl_s1_q, scl_s2_q};
      {sda_s1_q, sda_s2_q, sda_h_q} <= {bus.sda_i, sda_s1_q, sda_s2_q};
    end
  end

  // Bus write is placed last so it wins over a same-cycle host write.
  always_ff @(posedge clk) begin
    if (bus.host_we) mem_q[bus.host_addr] <= bus.host_wdata;
    if (bus_we)      mem_q[ptr_q]         <= shift_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      ptr_q      <= '0;
      first_q    <= 1'b0;
      rw_q       <= 1'b0;
      ack_ph_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_ptr_q   <= '0;
      rx_data_q  <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      if (start_c) begin
        state_q   <= ADDR;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
      end else if (stop_c) begin
        state_q  <= IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: ;
          ADDR: if (scl_rise) begin
            shift_q   <= shift_d[DW-2:0];
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (last_bit) begin
              if (shift_d[DW-1 -: AW] == SLAVE_ADDR) begin
                state_q  <= ADDR_ACK;
                first_q  <= 1'b1;
                rw_q     <= shift_d[0];
                ack_ph_q <= 1'b0;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
          ADDR_ACK: if (scl_fall) begin
            if (!ack_ph_q) begin
              sda_oe_q <= 1'b1;
              busy_q   <= 1'b1;
              ack_ph_q <= 1'b1;
            end else if (!rw_q) begin
              sda_oe_q  <= 1'b0;
              state_q   <= WR_BYTE;
              bit_cnt_q <= '0;
            end else begin
              tx_q      <= rd_word[DW-2:0];
              sda_oe_q  <= ~rd_word[DW-1];
              state_q   <= RD_BYTE;
              bit_cnt_q <= '0;
            end
          end
          WR_BYTE: if (scl_rise) begin
            shift_q   <= shift_d[DW-2:0];
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (last_bit) begin
              if (first_q) begin
                ptr_q   <= shift_d[PTR_WIDTH-1:0];
                first_q <= 1'b0;
              end else begin
                rx_valid_q <= 1'b1;
                rx_ptr_q   <= ptr_q;
                rx_data_q  <= shift_d;
                ptr_q      <= ptr_q + 1'b1;
              end
              state_q  <= WR_ACK;
              ack_ph_q <= 1'b0;
            end
          end
          WR_ACK: if (scl_fall) begin
            if (!ack_ph_q) begin
              sda_oe_q <= 1'b1;
              ack_ph_q <= 1'b1;
            end else begin
              sda_oe_q  <= 1'b0;
              state_q   <= WR_BYTE;
              bit_cnt_q <= '0;
            end
          end
          RD_BYTE: if (scl_fall) begin
            if (last_bit) begin
              sda_oe_q <= 1'b0;
              ptr_q    <= ptr_q + 1'b1;
              state_q  <= RD_ACK;
              ack_ph_q <= 1'b0;
            end else begin
              sda_oe_q  <= ~tx_q[DW-2];
              tx_q      <= {tx_q[DW-3:0], 1'b0};
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
          RD_ACK: begin
            // ack_ph_q marks that the controller ACKed and another byte follows.
            if (scl_rise && !ack_ph_q) begin
              if (sda_s2_q) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end else begin
                ack_ph_q <= 1'b1;
              end
            end else if (scl_fall && ack_ph_q) begin
              tx_q      <= rd_word[DW-2:0];
              sda_oe_q  <= ~rd_word[DW-1];
              state_q   <= RD_BYTE;
              bit_cnt_q <= '0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench: bit-level I2C controller model against the responder, hand-computed expectations.
`timescale 1ns/1ps
module tb_i2c_slave_responder;
  localparam int Q = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       host_we = 1'b0;
  logic [3:0] host_addr = '0;
  logic [7:0] host_wdata = '0;

  int n_chk = 0;
  int n_pass = 0;
  int oe_cnt = 0;
  logic [3:0] rx_p [$];
  logic [7:0] rx_d [$];

  i2c_slave_responder_if #(.DW(8), .PW(4)) bus ();

  assign bus.scl_i      = scl_m;
  assign bus.sda_i      = sda_m & ~bus.sda_oe;
  assign bus.host_we    = host_we;
  assign bus.host_addr  = host_addr;
  assign bus.host_wdata = host_wdata;

  i2c_slave_responder #(
    .I2C_ADDR_WIDTH(7), .I2C_DATA_WIDTH(8), .SLAVE_ADDR(7'h22), .PTR_WIDTH(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.sda_oe) oe_cnt <= oe_cnt + 1;
    if (bus.rx_valid) begin
      rx_p.push_back(bus.rx_ptr);
      rx_d.push_back(bus.rx_data);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic wr_bit(input logic b);
    sda_m = b; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
  endtask

  task automatic rd_bit(output logic b);
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; b = bus.sda_i; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wr_bit(d[i]);
    rd_bit(ack);
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) rd_bit(d[i]);
    wr_bit(nack);
  endtask

  task automatic host_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk); host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk); host_we = 1'b0;
  endtask

  task automatic host_rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk); host_addr = a; #1; d = bus.host_rdata;
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    logic [7:0] snap;
    int         oe0;

    repeat (4) @(negedge clk);
    check("reset_sda_oe", bus.sda_oe, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_rx_valid", bus.rx_valid, 0);
    check("reset_rx_ptr", bus.rx_ptr, 0);
    check("reset_rx_data", bus.rx_data, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Write: pointer 5, then A5, 5A.
    i2c_start();
    wr_byte(8'h44, ack); check("t1_addr_ack", ack, 0);
    check("t1_busy", bus.busy, 1);
    wr_byte(8'h05, ack); check("t1_ptr_ack", ack, 0);
    wr_byte(8'hA5, ack); check("t1_d0_ack", ack, 0);
    wr_byte(8'h5A, ack); check("t1_d1_ack", ack, 0);
    i2c_stop();
    repeat (5) @(negedge clk);
    check("t1_busy_after_stop", bus.busy, 0);
    check("t1_rx_count", rx_p.size(), 2);
    if (rx_p.size() >= 2) begin
      check("t1_rx0_ptr", rx_p[0], 5); check("t1_rx0_dat", rx_d[0], 8'hA5);
      check("t1_rx1_ptr", rx_p[1], 6); check("t1_rx1_dat", rx_d[1], 8'h5A);
    end
    host_rd(4'd5, d); check("t1_mem5", d, 8'hA5);
    host_rd(4'd6, d); check("t1_mem6", d, 8'h5A);

    // Pointer write, repeated START, read two bytes.
    i2c_start();
    wr_byte(8'h44, ack); check("t2_addr_w_ack", ack, 0);
    wr_byte(8'h05, ack); check("t2_ptr_ack", ack, 0);
    i2c_start();
    wr_byte(8'h45, ack); check("t2_addr_r_ack", ack, 0);
    rd_byte(1'b0, d); check("t2_rd0", d, 8'hA5);
    rd_byte(1'b1, d); check("t2_rd1", d, 8'h5A);
    repeat (5) @(negedge clk);
    check("t2_oe_after_nack", bus.sda_oe, 0);
    check("t2_busy_after_nack", bus.busy, 0);
    i2c_stop();
    check("t2_rx_count", rx_p.size(), 2);

    // Address mismatch: nothing answers, nothing stored.
    host_rd(4'd5, snap);
    oe0 = oe_cnt;
    i2c_start();
    wr_byte(8'hA0, ack); check("t3_addr_nack", ack, 1);
    wr_byte(8'h05, ack);
    wr_byte(8'h99, ack);
    i2c_stop();
    repeat (5) @(negedge clk);
    check("t3_oe_never", oe_cnt - oe0, 0);
    check("t3_busy", bus.busy, 0);
    check("t3_rx_count", rx_p.size(), 2);
    host_rd(4'd5, d); check("t3_mem5_kept", d, snap);

    // Pointer wrap on read.
    host_wr(4'd15, 8'h11);
    host_wr(4'd0, 8'h22);
    i2c_start();
    wr_byte(8'h44, ack); check("t4_addr_ack", ack, 0);
    wr_byte(8'h0F, ack); check("t4_ptr_ack", ack, 0);
    i2c_stop();
    i2c_start();
    wr_byte(8'h45, ack); check("t4_addr_r_ack", ack, 0);
    rd_byte(1'b0, d); check("t4_rd15", d, 8'h11);
    rd_byte(1'b1, d); check("t4_rd0", d, 8'h22);
    i2c_stop();

    // Pointer wrap on write.
    i2c_start();
    wr_byte(8'h44, ack);
    wr_byte(8'h0F, ack);
    wr_byte(8'h33, ack); check("t5_d0_ack", ack, 0);
    wr_byte(8'h44, ack); check("t5_d1_ack", ack, 0);
    i2c_stop();
    repeat (5) @(negedge clk);
    check("t5_rx_count", rx_p.size(), 4);
    if (rx_p.size() >= 4) begin
      check("t5_rx2_ptr", rx_p[2], 15); check("t5_rx2_dat", rx_d[2], 8'h33);
      check("t5_rx3_ptr", rx_p[3], 0);  check("t5_rx3_dat", rx_d[3], 8'h44);
    end
    host_rd(4'd15, d); check("t5_mem15", d, 8'h33);
    host_rd(4'd0, d);  check("t5_mem0", d, 8'h44);

    // Reset while the target holds SDA in the address ACK slot.
    i2c_start();
    for (int i = 7; i >= 0; i--) wr_bit(logic'((8'h44 >> i) & 1));
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q;
    check("t6_oe_in_ack", bus.sda_oe, 1);
    rst_n = 1'b0; #1;
    check("t6_oe_async_drop", bus.sda_oe, 0);
    check("t6_busy_reset", bus.busy, 0);
    #Q; scl_m = 1'b0; #Q;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    i2c_stop();
    i2c_start();
    wr_byte(8'h45, ack); check("t6_addr_r_ack", ack, 0);
    rd_byte(1'b1, d); check("t6_rd_ptr0", d, 8'h44);
    i2c_stop();
    repeat (5) @(negedge clk);
    check("t6_busy_end", bus.busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
